alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the combinational Basys3 ALU. Operands and opcode are accepted under a valid/ready handshake and pass through two register stages. Each result leaves with status flags (zero, negative, carry, overflow, illegal-opcode) and honours downstream backpressure without losing or reordering operations. It sits between the operand-capture logic (switches/buttons or a future UART front end) and the result display/consumer.

## Interface
- NB_DATA, 8, operand/result width in bits (≥2)
- NB_OPCODE, 6, opcode width in bits
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream presents an operation
- o_ready  out  1  block can accept this cycle
- i_op_1  in  NB_DATA  operand A, two's complement
- i_op_2  in  NB_DATA  operand B; shift amount (unsigned) for shifts
- i_opcode  in  NB_OPCODE  operation select
- o_valid  out  1  result/flags valid
- i_ready  in  1  downstream accepts result
- o_result  out  NB_DATA  result
- o_zero, o_negative, o_carry, o_overflow, o_illegal  out  1 each  status flags

## Operation
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010, SLL 000000. Every other code is illegal.
- Arithmetic:
  - ADD/SUB are modulo 2^NB_DATA.
  - ADD: o_carry = unsigned carry-out.
  - SUB: o_carry = borrow, i.e. unsigned op1 < op2.
  - o_overflow = signed overflow, for ADD/SUB only.
- Shifts:
  - Shift amount is the full unsigned value of i_op_2.
  - Amount ≥ NB_DATA gives 0 for SRL/SLL and all copies of op1's MSB for SRA.
  - o_carry = 0.
- Logic ops: o_carry = o_overflow = 0.
- o_zero = (o_result == 0). o_negative = o_result MSB. Both apply to legal opcodes only.
- Illegal opcode: o_result = 0, o_illegal = 1, all other flags 0.
- Stage 1 (S1) registers op1, op2 and opcode. The ALU function and flags are computed from S1 and registered into stage 2 (S2). S2 drives all outputs.
- Transfer rules:
  - Accept: i_valid & o_ready.
  - Emit: o_valid & i_ready.
  - adv2 = !s2_valid | i_ready
  - o_ready = !s1_valid | adv2 (combinational; no combinational path from i_valid).
- Pipeline update:
  - S2 loads from S1 when adv2.
  - s2_valid becomes s1_valid when adv2, and holds otherwise.
  - S1 loads when o_ready.
  - s1_valid becomes i_valid when o_ready.
- While o_valid & !i_ready, o_result and all flags hold stable.

## Timing
- Reset (asynchronous, immediate):
  - s1_valid = s2_valid = 0.
  - o_valid = 0, o_result = 0, all flags 0.
  - o_ready = 1 once reset is applied.
  - Data registers clear to 0.
- Latency: accept on edge N, o_valid high after edge N+1, consumable at edge N+2.
- Throughput: one op per cycle with i_ready held high.
- Full: both stages valid and i_ready low gives o_ready = 0. The upstream op is held by the upstream side, not dropped.
- Simultaneous emit and accept while full: o_ready = 1 in the same cycle. Both stages shift, no bubble.
- Empty: o_valid = 0. Outputs keep their last value and are don't-care for checking.
- Reset mid-operation: all in-flight ops are discarded. No o_valid pulse appears after reset deasserts until a new accept plus 2 edges.
- Opcode is sampled only on accept; changes while stalled have no effect.

## Test plan
- ADD 0x7F + 0x01, i_ready = 1:
  - o_valid exactly 2 edges after accept.
  - o_result = 0x80, o_overflow = 1, o_negative = 1, o_carry = 0, o_zero = 0.
- SUB 0x00 − 0x01 → 0xFF, carry = 1, overflow = 0. ADD 0xFF + 0x01 → 0x00, zero = 1, carry = 1, overflow = 0.
- Shifts:
  - SRA 0x80 by 3 → 0xF0.
  - SRA 0x80 by 200 → 0xFF.
  - SRL 0x80 by 9 → 0x00 with zero = 1.
  - SLL 0x81 by 1 → 0x02.
- Backpressure:
  - Issue 4 back-to-back ops with i_ready low for 5 cycles.
  - o_ready drops after 2 accepts; o_result/flags stay stable while stalled.
  - After i_ready rises, all 4 results emerge in order, one per cycle, with none lost or duplicated.
- Illegal opcode 0x3F with 0x00, 0x00 → o_result = 0x00, o_illegal = 1, o_zero = 0, other flags 0. The next legal op clears o_illegal.
- Assert i_reset asynchronously (mid-cycle) with 2 ops in flight:
  - o_valid falls immediately; o_ready = 1 while reset is held.
  - After release, no stale result appears.
  - A fresh ADD 0x03 + 0x04 returns 0x07 at latency 2.

Source files
------------

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU behind a valid/ready handshake. Stage 1 captures the
// operands and opcode. The ALU function and its status flags are computed from
// stage 1 and registered into stage 2, which drives every output. Backpressure
// from downstream stalls stage 2 first, then stage 1, and finally upstream
// through o_ready. Operations are never dropped and never reordered.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_reset     asynchronous, active-high reset
//   i_valid     upstream presents an operation
//   o_ready     pipeline can accept an operation this cycle
//   i_op_1      operand A (two's complement)
//   i_op_2      operand B, or the unsigned shift amount for shifts
//   i_opcode    operation select
//   o_valid     o_result and the flags hold a valid result
//   i_ready     downstream accepts the result this cycle
//   o_result    ALU result
//   o_zero      result is zero (legal opcodes only)
//   o_negative  result MSB (legal opcodes only)
//   o_carry     ADD carry-out / SUB borrow
//   o_overflow  signed overflow for ADD/SUB
//   o_illegal   opcode is not a supported operation
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_DATA-1:0]   i_op_1,
    input  logic [NB_DATA-1:0]   i_op_2,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_zero,
    output logic                 o_negative,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_illegal
);

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
    localparam logic [NB_OPCODE-1:0] OP_SLL = NB_OPCODE'(6'b000000);

    localparam int MSB = NB_DATA - 1;

    // Stage 1 registers
    logic                 s1Valid_q;
    logic [NB_DATA-1:0]   s1Op1_q;
    logic [NB_DATA-1:0]   s1Op2_q;
    logic [NB_OPCODE-1:0] s1Opcode_q;

    // Stage 2 registers
    logic                 s2Valid_q;
    logic [NB_DATA-1:0]   result_q;
    logic                 zero_q;
    logic                 negative_q;
    logic                 carry_q;
    logic                 overflow_q;
    logic                 illegal_q;

    // Next-state values for stage 2, computed from stage 1
    logic [NB_DATA-1:0]   result_d;
    logic                 zero_d;
    logic                 negative_d;
    logic                 carry_d;
    logic                 overflow_d;
    logic                 illegal_d;
    logic [NB_DATA:0]     sumWide;
    logic [NB_DATA:0]     diffWide;

    logic                 adv2;

    // Stage 2 may move when it is empty or its result is being consumed.
    // Stage 1 may accept when it is empty or about to hand over to stage 2.
    // Neither term looks at i_valid, so o_ready has no path from i_valid.
    assign adv2    = !s2Valid_q || i_ready;
    assign o_ready = !s1Valid_q || adv2;

    // Stage 1 capture. Data registers load only on a real accept, so whatever
    // sits on the operand/opcode lines while nothing is accepted has no effect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1Valid_q  <= 1'b0;
            s1Op1_q    <= '0;
            s1Op2_q    <= '0;
            s1Opcode_q <= '0;
        end else if (o_ready) begin
            s1Valid_q <= i_valid;
            if (i_valid) begin
                s1Op1_q    <= i_op_1;
                s1Op2_q    <= i_op_2;
                s1Opcode_q <= i_opcode;
            end
        end
    end

    // ALU function and flags. Both ADD and SUB are done one bit wider so that
    // the top bit gives the carry-out (ADD) or the borrow (SUB) directly.
    // Shifts use the full operand B as the amount; SV shift semantics already
    // give zero (logical) or sign fill (arithmetic) once the amount reaches
    // NB_DATA.
    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        sumWide    = {1'b0, s1Op1_q} + {1'b0, s1Op2_q};
        diffWide   = {1'b0, s1Op1_q} - {1'b0, s1Op2_q};
        case (s1Opcode_q)
            OP_ADD: begin
                result_d   = sumWide[MSB:0];
                carry_d    = sumWide[NB_DATA];
                overflow_d = (s1Op1_q[MSB] == s1Op2_q[MSB]) &&
                             (sumWide[MSB] != s1Op1_q[MSB]);
            end
            OP_SUB: begin
                result_d   = diffWide[MSB:0];
                carry_d    = diffWide[NB_DATA];
                overflow_d = (s1Op1_q[MSB] != s1Op2_q[MSB]) &&
                             (diffWide[MSB] != s1Op1_q[MSB]);
            end
            OP_AND:  result_d = s1Op1_q & s1Op2_q;
            OP_OR:   result_d = s1Op1_q | s1Op2_q;
            OP_XOR:  result_d = s1Op1_q ^ s1Op2_q;
            OP_NOR:  result_d = ~(s1Op1_q | s1Op2_q);
            OP_SRA:  result_d = $signed(s1Op1_q) >>> s1Op2_q;
            OP_SRL:  result_d = s1Op1_q >> s1Op2_q;
            OP_SLL:  result_d = s1Op1_q << s1Op2_q;
            default: illegal_d = 1'b1;
        endcase
        // An illegal opcode reports only o_illegal, never zero/negative.
        zero_d     = !illegal_d && (result_d == '0);
        negative_d = !illegal_d && result_d[MSB];
    end

    // Stage 2 register. It holds still while a result waits for i_ready, and
    // keeps its last data when a bubble passes through.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2Valid_q  <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (adv2) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                result_q   <= result_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign o_valid    = s2Valid_q;
    assign o_result   = result_q;
    assign o_zero     = zero_q;
    assign o_negative = negative_q;
    assign o_carry    = carry_q;
    assign o_overflow = overflow_q;
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe (NB_DATA = 8, NB_OPCODE = 6). A negedge
// monitor keeps a queue of expected results computed with plain integer
// arithmetic, pushes one entry per accept, pops one per emit, and also checks
// that outputs hold while stalled. Directed operations pin the model and the
// latency against hand-computed literals; a random phase exercises the
// handshake with random valid/ready patterns.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int NB_DATA   = 8;
    localparam int NB_OPCODE = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SLL = 6'b000000;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_op_1;
    logic [7:0] i_op_2;
    logic [5:0] i_opcode;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result;
    logic       o_zero;
    logic       o_negative;
    logic       o_carry;
    logic       o_overflow;
    logic       o_illegal;

    // {result, zero, negative, carry, overflow, illegal}
    logic [12:0] dutOut;
    assign dutOut = {o_result, o_zero, o_negative, o_carry, o_overflow, o_illegal};

    int checks    = 0;
    int errors    = 0;
    int emitCount = 0;

    logic [12:0] expQ[$];
    logic        prevStall = 1'b0;
    logic [12:0] heldOut   = '0;

    logic [5:0] legalOps[9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                                OP_NOR, OP_SRA, OP_SRL, OP_SLL};
    logic [7:0] edgeVals[4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    alu_pipe #(
        .NB_DATA  (NB_DATA),
        .NB_OPCODE(NB_OPCODE)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op_1    (i_op_1),
        .i_op_2    (i_op_2),
        .i_opcode  (i_opcode),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_zero    (o_zero),
        .o_negative(o_negative),
        .o_carry   (o_carry),
        .o_overflow(o_overflow),
        .o_illegal (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic straight from the operation rules.
    function automatic logic [12:0] modelAlu(input logic [5:0] opc,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        int ua, ub, sa, sb, r, sr;
        bit c, v, ill;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        r = 0; c = 0; v = 0; ill = 0;
        case (opc)
            OP_ADD: begin
                r = (ua + ub) % 256;
                c = (ua + ub) >= 256;
                sr = sa + sb;
                v = (sr > 127) || (sr < -128);
            end
            OP_SUB: begin
                r = (ua - ub + 256) % 256;
                c = ua < ub;
                sr = sa - sb;
                v = (sr > 127) || (sr < -128);
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOR: r = 255 - (ua | ub);
            OP_SRL: r = (ub >= 8) ? 0 : (ua >> ub);
            OP_SLL: r = (ub >= 8) ? 0 : ((ua << ub) % 256);
            OP_SRA: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
            default: ill = 1;
        endcase
        return {8'(r), (!ill && r == 0), (!ill && r >= 128), c, v, ill};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Monitor: at each negedge the handshake signals show what the next
    // rising edge will do, so emits pop and accepts push here.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall)
                checkOutput("stall_hold", 32'(dutOut), 32'(heldOut));
            if (o_valid && i_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 32'(dutOut), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("scoreboard", 32'(dutOut), 32'(expQ.pop_front()));
                end
                emitCount++;
            end
            if (i_valid && o_ready)
                expQ.push_back(modelAlu(i_opcode, i_op_1, i_op_2));
            prevStall = o_valid && !i_ready;
            heldOut   = dutOut;
        end
    end

    // One operation into an empty pipeline with i_ready high; checks exact
    // latency and the literal result/flags.
    task automatic applyStimulus(input string name, input logic [5:0] opc,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [12:0] expected);
        @(posedge clk); #1;
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_opcode = opc;
        i_op_1   = a;
        i_op_2   = b;
        @(posedge clk); #1;
        i_valid = 1'b0;
        checkOutput({name, "_valid_at_1"}, 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, "_valid_at_2"}, 32'(o_valid), 32'd1);
        checkOutput(name, 32'(dutOut), 32'(expected));
    endtask

    // Present an operation and hold it until accepted (bounded).
    task automatic sendOp(input logic [5:0] opc, input logic [7:0] a,
                          input logic [7:0] b);
        i_valid  = 1'b1;
        i_opcode = opc;
        i_op_1   = a;
        i_op_2   = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (o_ready) begin
                @(posedge clk); #1;
                i_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checkOutput("send_timeout", 32'd1, 32'd0);
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pickOpcode();
        if ($urandom_range(0, 7) == 0)
            return 6'($urandom_range(0, 63));
        return legalOps[$urandom_range(0, 8)];
    endfunction

    function automatic logic [7:0] pickOperand();
        if ($urandom_range(0, 3) == 0)
            return edgeVals[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int startEmits;
        bit wasAcc;

        rst      = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_op_1   = '0;
        i_op_2   = '0;
        i_opcode = '0;

        #2;
        checkOutput("reset_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_ready", 32'(o_ready), 32'd1);
        checkOutput("reset_outputs", 32'(dutOut), 32'd0);
        #10;
        rst = 1'b0;
        idle(2);

        // Directed operations with hand-computed results
        applyStimulus("add_7f_01",  OP_ADD, 8'h7F, 8'h01, {8'h80, 5'b01010});
        applyStimulus("sub_00_01",  OP_SUB, 8'h00, 8'h01, {8'hFF, 5'b01100});
        applyStimulus("add_ff_01",  OP_ADD, 8'hFF, 8'h01, {8'h00, 5'b10100});
        applyStimulus("sra_80_3",   OP_SRA, 8'h80, 8'd3,  {8'hF0, 5'b01000});
        applyStimulus("sra_80_200", OP_SRA, 8'h80, 8'd200, {8'hFF, 5'b01000});
        applyStimulus("srl_80_9",   OP_SRL, 8'h80, 8'd9,  {8'h00, 5'b10000});
        applyStimulus("sll_81_1",   OP_SLL, 8'h81, 8'd1,  {8'h02, 5'b00000});
        applyStimulus("illegal_3f", 6'h3F,  8'h00, 8'h00, {8'h00, 5'b00001});
        applyStimulus("and_clears", OP_AND, 8'hF0, 8'h3C, {8'h30, 5'b00000});
        applyStimulus("nor_00_00",  OP_NOR, 8'h00, 8'h00, {8'hFF, 5'b01000});
        idle(3);

        // Backpressure: fill the pipe with i_ready low, then release
        startEmits = emitCount;
        i_ready = 1'b0;
        sendOp(OP_ADD, 8'h10, 8'h20);
        sendOp(OP_XOR, 8'h55, 8'hFF);
        i_valid  = 1'b1;
        i_opcode = OP_SUB;
        i_op_1   = 8'h05;
        i_op_2   = 8'h09;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("full_ready_low", 32'(o_ready), 32'd0);
            checkOutput("full_valid_high", 32'(o_valid), 32'd1);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        sendOp(OP_SUB, 8'h05, 8'h09);
        sendOp(OP_SLL, 8'h01, 8'd7);
        idle(5);
        checkOutput("bp_emit_count", 32'(emitCount - startEmits), 32'd4);
        checkOutput("bp_queue_empty", 32'(expQ.size()), 32'd0);

        // Asynchronous reset with two operations in flight
        i_ready = 1'b0;
        sendOp(OP_ADD, 8'h01, 8'h02);
        sendOp(OP_OR,  8'h0F, 8'hF0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_valid", 32'(o_valid), 32'd0);
        checkOutput("midreset_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("midreset_ready_held", 32'(o_ready), 32'd1);
        #2;
        rst = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("post_reset_no_stale", 32'(o_valid), 32'd0);
        end
        applyStimulus("add_03_04", OP_ADD, 8'h03, 8'h04, {8'h07, 5'b00000});
        idle(3);

        // Random handshake traffic against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            wasAcc = i_valid && o_ready;
            @(posedge clk); #1;
            if (!i_valid || wasAcc) begin
                i_valid  = ($urandom_range(0, 3) != 0);
                i_opcode = pickOpcode();
                i_op_1   = pickOperand();
                i_op_2   = pickOperand();
            end
            i_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        wasAcc = i_valid && o_ready;
        @(posedge clk); #1;
        if (i_valid && !wasAcc) begin
            i_ready = 1'b1;
            sendOp(i_opcode, i_op_1, i_op_2);
        end
        idle(6);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
